// File: rtl/mux_nx1_pipe_if.sv
// rtl/mux_nx1_pipe_if.sv - handshake/data bundle for the N:1 pipelined mux
// master drives the channel inputs and downstream ready; slave is the mux.
interface mux_nx1_pipe_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_IN        = 4,
    parameter int COMMAND_WIDTH = 2
);
    logic [NUM_IN*DATA_WIDTH-1:0] i_data_bus;
    logic [NUM_IN-1:0]            i_valid;
    logic [NUM_IN-1:0]            o_ready;
    logic                         i_en;
    logic                         i_mode;
    logic [COMMAND_WIDTH-1:0]     i_cmd;
    logic [DATA_WIDTH-1:0]        o_data_bus;
    logic                         o_valid;
    logic [COMMAND_WIDTH-1:0]     o_src_id;
    logic                         i_ready;

    modport master (
        output i_data_bus, i_valid, i_en, i_mode, i_cmd, i_ready,
        input  o_ready, o_data_bus, o_valid, o_src_id
    );

    modport slave (
        input  i_data_bus, i_valid, i_en, i_mode, i_cmd, i_ready,
        output o_ready, o_data_bus, o_valid, o_src_id
    );
endinterface

// File: rtl/mux_nx1_pipe.sv
// rtl/mux_nx1_pipe.sv - N:1 valid/ready mux with registered, stallable output stage
// Optional round-robin arbitration compiled in with MUX_NX1_PIPE_RR_ARB_EN.
module mux_nx1_pipe #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_IN        = 4,
    parameter int COMMAND_WIDTH = 2
) (
    input logic            clk,
    input logic            rst_n,
    mux_nx1_pipe_if.slave  bus
);
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     valid_q, valid_d;
    logic [COMMAND_WIDTH-1:0] src_id_q, src_id_d;

    logic                     load;
    logic                     grant_vld;
    logic [COMMAND_WIDTH-1:0] grant_idx;
    logic                     xfer;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [NUM_IN-1:0]        ready;

`ifdef MUX_NX1_PIPE_RR_ARB_EN
    logic [COMMAND_WIDTH-1:0] ptr_q, ptr_d;
    logic                     rr_mode;
    assign rr_mode = bus.i_mode;
`endif

    assign load = !valid_q || bus.i_ready;
    assign xfer = grant_vld && load;

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (bus.i_en) begin
`ifdef MUX_NX1_PIPE_RR_ARB_EN
            if (rr_mode) begin
                // Search starts at ptr and wraps; first valid channel wins.
                for (int off = 0; off < NUM_IN; off++) begin
                    idx = int'(ptr_q) + off;
                    if (idx >= NUM_IN) idx = idx - NUM_IN;
                    if (!grant_vld && bus.i_valid[idx]) begin
                        grant_vld = 1'b1;
                        grant_idx = COMMAND_WIDTH'(idx);
                    end
                end
            end else
`endif
            begin
                // Out-of-range commands match no channel and never grant.
                for (int k = 0; k < NUM_IN; k++) begin
                    if (bus.i_cmd == COMMAND_WIDTH'(k) && bus.i_valid[k]) begin
                        grant_vld = 1'b1;
                        grant_idx = COMMAND_WIDTH'(k);
                    end
                end
            end
        end
    end

    always_comb begin
        ready    = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            ready[k] = grant_vld && load && (grant_idx == COMMAND_WIDTH'(k));
            if (grant_idx == COMMAND_WIDTH'(k)) sel_data = bus.i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.o_ready = ready;

    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        src_id_d = src_id_q;
`ifdef MUX_NX1_PIPE_RR_ARB_EN
        ptr_d    = ptr_q;
`endif
        if (xfer) begin
            data_d   = sel_data;
            valid_d  = 1'b1;
            src_id_d = grant_idx;
`ifdef MUX_NX1_PIPE_RR_ARB_EN
            if (rr_mode) begin
                ptr_d = (grant_idx == COMMAND_WIDTH'(NUM_IN - 1)) ? '0 : grant_idx + COMMAND_WIDTH'(1);
            end
`endif
        end else if (bus.i_ready) begin
            // Consumed with nothing to replace it: park on the zero dummy word.
            data_d   = '0;
            valid_d  = 1'b0;
            src_id_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            src_id_q <= '0;
`ifdef MUX_NX1_PIPE_RR_ARB_EN
            ptr_q    <= '0;
`endif
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            src_id_q <= src_id_d;
`ifdef MUX_NX1_PIPE_RR_ARB_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign bus.o_data_bus = data_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_src_id   = src_id_q;
endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb/tb_mux_nx1_pipe.sv - scoreboard bench for mux_nx1_pipe (4-input and 3-input instances)
module tb_mux_nx1_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_nx1_pipe_if #(.DATA_WIDTH(32), .NUM_IN(4), .COMMAND_WIDTH(2)) bus ();
    mux_nx1_pipe_if #(.DATA_WIDTH(32), .NUM_IN(3), .COMMAND_WIDTH(2)) bus3 ();

    mux_nx1_pipe #(.DATA_WIDTH(32), .NUM_IN(4), .COMMAND_WIDTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    mux_nx1_pipe #(.DATA_WIDTH(32), .NUM_IN(3), .COMMAND_WIDTH(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] chdata [4];
    int          pass_cnt = 0;
    int          total    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one cycle of stimulus, check o_ready, and queue the word that will load.
    task automatic cyc(input logic [3:0] v, input logic [1:0] cmd, input logic en,
                       input logic mode, input logic rdy, input logic [3:0] exp_rdy,
                       input logic push = 1'b1);
        exp_t e;
        bus.i_valid = v;
        bus.i_cmd   = cmd;
        bus.i_en    = en;
        bus.i_mode  = mode;
        bus.i_ready = rdy;
        for (int k = 0; k < 4; k++) bus.i_data_bus[k*32 +: 32] = chdata[k];
        @(negedge clk);
        chk("o_ready", {28'h0, bus.o_ready}, {28'h0, exp_rdy});
        if (exp_rdy != 4'h0 && push) begin
            for (int k = 0; k < 4; k++) begin
                if (exp_rdy[k]) begin
                    e.d = chdata[k];
                    e.s = 2'(k);
                end
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.o_valid && bus.i_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: got data %0h src %0d expected no word", bus.o_data_bus, bus.o_src_id);
            end else begin
                e = sb.pop_front();
                chk("sb_data", bus.o_data_bus, e.d);
                chk("sb_src", {30'h0, bus.o_src_id}, {30'h0, e.s});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) chdata[k] = 32'h100 + k;
        bus.i_valid = 4'hF;
        bus.i_cmd   = 2'd2;
        bus.i_en    = 1'b1;
        bus.i_mode  = 1'b0;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 4; k++) bus.i_data_bus[k*32 +: 32] = chdata[k];
        bus3.i_data_bus = {32'h302, 32'h301, 32'h300};
        bus3.i_valid    = 3'b000;
        bus3.i_cmd      = 2'd0;
        bus3.i_en       = 1'b1;
        bus3.i_mode     = 1'b0;
        bus3.i_ready    = 1'b1;

        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", {31'h0, bus.o_valid}, 32'h0);
            chk("rst_data", bus.o_data_bus, 32'h0);
            chk("rst_src", {30'h0, bus.o_src_id}, 32'h0);
        end
        bus.i_valid = 4'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc(4'hF, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0100);

        for (int i = 0; i < 8; i++) begin
            chdata[1] = 32'h10 + i;
            cyc(4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 4'b0010);
        end
        cyc(4'b0000, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000);
        chk("idle_valid", {31'h0, bus.o_valid}, 32'h0);
        chk("idle_data", bus.o_data_bus, 32'h0);

        chdata[0] = 32'hAA;
        cyc(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0001);
        repeat (3) begin
            cyc(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
            chk("bp_hold_data", bus.o_data_bus, 32'hAA);
            chk("bp_hold_valid", {31'h0, bus.o_valid}, 32'h1);
        end
        chdata[0] = 32'hBB;
        cyc(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0001);
        chk("bp_refill", bus.o_data_bus, 32'hBB);
        cyc(4'b0000, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000);

        chdata[2] = 32'h55;
        cyc(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0100);
        cyc(4'hF, 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000);
        cyc(4'hF, 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000);
        chk("dis_drained", {31'h0, bus.o_valid}, 32'h0);
        cyc(4'hF, 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000);

        bus3.i_valid = 3'b111;
        bus3.i_cmd   = 2'd0;
        @(negedge clk);
        chk("n3_ready_cmd0", {29'h0, bus3.o_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("n3_valid", {31'h0, bus3.o_valid}, 32'h1);
        chk("n3_data", bus3.o_data_bus, 32'h300);
        bus3.i_cmd = 2'd3;
        @(negedge clk);
        chk("n3_ready_oor", {29'h0, bus3.o_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("n3_valid_fall", {31'h0, bus3.o_valid}, 32'h0);
        chk("n3_data_zero", bus3.o_data_bus, 32'h0);

`ifdef MUX_NX1_PIPE_RR_ARB_EN
        for (int k = 0; k < 4; k++) chdata[k] = 32'h200 + k;
        cyc(4'hF, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0001);
        cyc(4'hF, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0010);
        cyc(4'hF, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0100);
        cyc(4'hF, 2'd0, 1'b1, 1'b1, 1'b1, 4'b1000);
        cyc(4'hF, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0001);
        cyc(4'b1010, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0010);
        cyc(4'b1010, 2'd0, 1'b1, 1'b1, 1'b1, 4'b1000);
        cyc(4'b1010, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0010);
        cyc(4'b1010, 2'd0, 1'b1, 1'b1, 1'b1, 4'b1000);
        cyc(4'b0100, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b0);
        chk("rr_inflight_src", {30'h0, bus.o_src_id}, 32'h2);
        rst_n = 1'b0;
        bus.i_valid = 4'hF;
        #1;
        chk("rr_async_clear", {31'h0, bus.o_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'hF, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0001);
        cyc(4'b0000, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0000);
`endif

        cyc(4'b0000, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000);
        chk("sb_empty", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
